// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch types and default FIFO depth
// Purpose: fetch entry record and the default instruction queue depth.
// Contents: CORE_XLEN (instruction/PC width), FIFO_DEPTH (default entries),
//           fetch_entry_t {instr, pc}.
package core_pkg;

    localparam int CORE_XLEN  = 32;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic [CORE_XLEN-1:0] instr;
        logic [CORE_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo_ram.sv
// rtl/instr_fifo_ram.sv - DEPTH x fetch_entry_t register array, 2W/2R
// Purpose: storage for the instruction queue; data is never reset.
// Ports:
//   clk                       rising-edge clock
//   wr_en0/wr_addr0/wr_data0  write port 0
//   wr_en1/wr_addr1/wr_data1  write port 1 (wins if both hit one address)
//   rd_addr0/rd_data0         asynchronous read port 0
//   rd_addr1/rd_data1         asynchronous read port 1
module instr_fifo_ram
    import core_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en0,
    input  logic [AW-1:0]     wr_addr0,
    input  fetch_entry_t      wr_data0,
    input  logic              wr_en1,
    input  logic [AW-1:0]     wr_addr1,
    input  fetch_entry_t      wr_data1,
    input  logic [AW-1:0]     rd_addr0,
    output fetch_entry_t      rd_data0,
    input  logic [AW-1:0]     rd_addr1,
    output fetch_entry_t      rd_data1
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en0) mem_q[wr_addr0] <= wr_data0;
        if (wr_en1) mem_q[wr_addr1] <= wr_data1;
    end

    assign rd_data0 = mem_q[rd_addr0];
    assign rd_data1 = mem_q[rd_addr1];

endmodule

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - dual-issue show-ahead instruction queue
// Purpose: takes up to two {instr, pc} pairs per cycle from fetch and presents
//          the two oldest entries to decode; flushed on taken jump, held on stall.
// Optional: FIFO_PERF_CNT_EN adds perf_full_cycles / perf_flush_count outputs.
// Ports:
//   clk, rst (async, active-high)      clock and reset
//   flush, stall                       discard all / hold read side
//   wr_valid1/2, wr_instr1/2, wr_pc1/2 fetch slots (slot 1 is older)
//   rd_valid1/2, rd_instr1/2, rd_pc1/2 decode slots (slot 1 is oldest)
//   fifo_full, fifo_empty, count       occupancy status
// XLEN must equal core_pkg::CORE_XLEN since entries use fetch_entry_t.
module instr_fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int XLEN  = CORE_XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     stall,
    input  logic                     wr_valid1,
    input  logic [XLEN-1:0]          wr_instr1,
    input  logic [XLEN-1:0]          wr_pc1,
    input  logic                     wr_valid2,
    input  logic [XLEN-1:0]          wr_instr2,
    input  logic [XLEN-1:0]          wr_pc2,
    output logic                     rd_valid1,
    output logic [XLEN-1:0]          rd_instr1,
    output logic [XLEN-1:0]          rd_pc1,
    output logic                     rd_valid2,
    output logic [XLEN-1:0]          rd_instr2,
    output logic [XLEN-1:0]          rd_pc2,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   count
`ifdef FIFO_PERF_CNT_EN
    ,
    output logic [31:0]              perf_full_cycles,
    output logic [31:0]              perf_flush_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    push_n, pop_n;

    fetch_entry_t  wdata0, wdata1, rdata0, rdata1;

    // Flags depend on registered count only, so fetch never sees a
    // combinational path from its own write request to fifo_full.
    assign rd_valid1  = (count_q != '0);
    assign rd_valid2  = (count_q >= CW'(2));
    assign fifo_full  = (count_q >= CW'(DEPTH - 1));
    assign fifo_empty = (count_q == '0);
    assign count      = count_q;

    // Decode consumes every valid slot it is shown.
    assign pop_n  = (!stall && !flush)
                  ? ({1'b0, rd_valid1} + {1'b0, rd_valid2}) : 2'd0;
    assign push_n = (!fifo_full && !flush)
                  ? ({1'b0, wr_valid1} + {1'b0, wr_valid2}) : 2'd0;

    // Compaction: the first valid fetch slot always lands at wr_ptr.
    assign wdata0 = wr_valid1 ? '{instr: wr_instr1, pc: wr_pc1}
                              : '{instr: wr_instr2, pc: wr_pc2};
    assign wdata1 = '{instr: wr_instr2, pc: wr_pc2};

    instr_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk      (clk),
        .wr_en0   (push_n != 2'd0),
        .wr_addr0 (wr_ptr_q),
        .wr_data0 (wdata0),
        .wr_en1   (push_n == 2'd2),
        .wr_addr1 (wr_ptr_q + PW'(1)),
        .wr_data1 (wdata1),
        .rd_addr0 (rd_ptr_q),
        .rd_data0 (rdata0),
        .rd_addr1 (rd_ptr_q + PW'(1)),
        .rd_data1 (rdata1)
    );

    assign rd_instr1 = rd_valid1 ? rdata0.instr : '0;
    assign rd_pc1    = rd_valid1 ? rdata0.pc    : '0;
    assign rd_instr2 = rd_valid2 ? rdata1.instr : '0;
    assign rd_pc2    = rd_valid2 ? rdata1.pc    : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_n);
        rd_ptr_d = rd_ptr_q + PW'(pop_n);
        count_d  = count_q + CW'(push_n) - CW'(pop_n);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FIFO_PERF_CNT_EN
    logic [31:0] perf_full_q, perf_flush_q;

    // Saturating; only rst clears them so they survive pipeline flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_full_q  <= '0;
            perf_flush_q <= '0;
        end else begin
            if (fifo_full && (perf_full_q != 32'hFFFF_FFFF))
                perf_full_q <= perf_full_q + 32'd1;
            if (flush && (perf_flush_q != 32'hFFFF_FFFF))
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_full_cycles = perf_full_q;
    assign perf_flush_count = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_fifo.sv
// tb/tb_instr_fetch_fifo.sv - scoreboard bench for instr_fetch_fifo
module tb_instr_fetch_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        wr_valid1 = 1'b0, wr_valid2 = 1'b0;
    logic [31:0] wr_instr1 = '0, wr_pc1 = '0, wr_instr2 = '0, wr_pc2 = '0;
    logic        rd_valid1, rd_valid2;
    logic [31:0] rd_instr1, rd_pc1, rd_instr2, rd_pc2;
    logic        fifo_full, fifo_empty;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];

    instr_fetch_fifo #(.DEPTH(8), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .stall      (stall),
        .wr_valid1  (wr_valid1),
        .wr_instr1  (wr_instr1),
        .wr_pc1     (wr_pc1),
        .wr_valid2  (wr_valid2),
        .wr_instr2  (wr_instr2),
        .wr_pc2     (wr_pc2),
        .rd_valid1  (rd_valid1),
        .rd_instr1  (rd_instr1),
        .rd_pc1     (rd_pc1),
        .rd_valid2  (rd_valid2),
        .rd_instr2  (rd_instr2),
        .rd_pc2     (rd_pc2),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: decode consumes every presented slot at an edge without stall/flush.
    task automatic pop_cmp(input int slot, input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL slot%0d_unexpected: got pc %0h, expected no entry", slot, pc);
        end else begin
            e = exp_q.pop_front();
            if (instr !== e.instr || pc !== e.pc) begin
                n_fail++;
                $display("FAIL slot%0d_data: got %0h@%0h expected %0h@%0h",
                         slot, instr, pc, e.instr, e.pc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !stall && !flush) begin
            if (rd_valid1) pop_cmp(1, rd_instr1, rd_pc1);
            if (rd_valid2) pop_cmp(2, rd_instr2, rd_pc2);
        end
    end

    // One cycle of stimulus; acc says whether the hand analysis expects
    // the writes to be accepted (and so appear at decode later).
    task automatic step(input logic v1, input logic [31:0] i1, input logic [31:0] p1,
                        input logic v2, input logic [31:0] i2, input logic [31:0] p2,
                        input logic st, input logic fl, input logic acc);
        exp_t e;
        wr_valid1 = v1; wr_instr1 = i1; wr_pc1 = p1;
        wr_valid2 = v2; wr_instr2 = i2; wr_pc2 = p2;
        stall = st; flush = fl;
        if (fl) exp_q.delete();
        if (acc) begin
            if (v1) begin e.instr = i1; e.pc = p1; exp_q.push_back(e); end
            if (v2) begin e.instr = i2; e.pc = p2; exp_q.push_back(e); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st);
        step(1'b0, '0, '0, 1'b0, '0, '0, st, 1'b0, 1'b0);
    endtask

    task automatic pair(input logic [31:0] pc, input logic st, input logic acc);
        step(1'b1, instr_of(pc), pc, 1'b1, instr_of(pc + 4), pc + 4, st, 1'b0, acc);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_empty", 64'(fifo_empty), 64'd1);
        chk("reset_full", 64'(fifo_full), 64'd0);
        chk("reset_valids", 64'({rd_valid1, rd_valid2}), 64'd0);
        chk("reset_rd_data", {rd_pc1, rd_instr2}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(1'b0);

        // First pair, visible one cycle later.
        step(1'b1, 32'h0000_0013, 32'h0, 1'b1, 32'h0010_0093, 32'h4, 1'b1, 1'b0, 1'b1);
        chk("t1_valids", 64'({rd_valid1, rd_valid2}), 64'd3);
        chk("t1_pc1", 64'(rd_pc1), 64'h0);
        chk("t1_pc2", 64'(rd_pc2), 64'h4);
        chk("t1_count", 64'(count), 64'd2);
        idle(1'b0);
        chk("t1_drained", 64'(count), 64'd0);

        // Fill to 7 under stall, drop a write while full, release stall.
        pair(32'h10, 1'b1, 1'b1);
        pair(32'h18, 1'b1, 1'b1);
        pair(32'h20, 1'b1, 1'b1);
        chk("t2_count6", 64'(count), 64'd6);
        chk("t2_notfull6", 64'(fifo_full), 64'd0);
        step(1'b1, instr_of(32'h28), 32'h28, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("t2_count7", 64'(count), 64'd7);
        chk("t2_full7", 64'(fifo_full), 64'd1);
        step(1'b1, instr_of(32'h40), 32'h40, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("t2_drop_count", 64'(count), 64'd7);
        idle(1'b0);
        chk("t2_pop_count", 64'(count), 64'd5);
        chk("t2_pop_full", 64'(fifo_full), 64'd0);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk("t2_empty", 64'(fifo_empty), 64'd1);

        // Slot-2-only write compacts into read slot 1.
        step(1'b0, '0, '0, 1'b1, instr_of(32'h8), 32'h8, 1'b1, 1'b0, 1'b1);
        chk("t3_pc1", 64'(rd_pc1), 64'h8);
        chk("t3_valid2", 64'(rd_valid2), 64'd0);
        chk("t3_count", 64'(count), 64'd1);
        idle(1'b0);

        // Flush wins over stall and a same-cycle push.
        pair(32'h50, 1'b1, 1'b1);
        step(1'b1, instr_of(32'h58), 32'h58, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("t4_count3", 64'(count), 64'd3);
        step(1'b1, instr_of(32'h60), 32'h60, 1'b1, instr_of(32'h64), 32'h64, 1'b1, 1'b1, 1'b0);
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_empty", 64'(fifo_empty), 64'd1);
        chk("t4_valid1", 64'(rd_valid1), 64'd0);
        idle(1'b0);
        chk("t4_still_empty", 64'(count), 64'd0);

        // Steady push 2 / pop 2, pointers wrap repeatedly.
        pair(32'h100, 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            pair(32'h100 + 32'(k * 8), 1'b0, 1'b1);
            chk("t5_count", 64'(count), 64'd2);
        end
        idle(1'b0);
        chk("t5_empty", 64'(fifo_empty), 64'd1);

        // Async reset in mid-cycle with six entries held.
        pair(32'h200, 1'b1, 1'b1);
        pair(32'h208, 1'b1, 1'b1);
        pair(32'h210, 1'b1, 1'b1);
        chk("t6_count6", 64'(count), 64'd6);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_empty", 64'(fifo_empty), 64'd1);
        chk("t6_valids", 64'({rd_valid1, rd_valid2}), 64'd0);
        chk("t6_rd_data", {rd_pc1, rd_instr1}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pair(32'h300, 1'b1, 1'b1);
        chk("t6_post_pc1", 64'(rd_pc1), 64'h300);
        idle(1'b0);
        idle(1'b0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_fifo.md
Name: instr_fetch_fifo

Overview:
- Dual-issue instruction queue between the instruction fetch/cache controller and the two decode slots.
- Accepts up to 2 {instruction, PC} pairs per cycle from fetch. Presents the 2 oldest entries, in order, to decode slots 1 and 2.
- Is flushed on a taken jump and held on a downstream stall. Reports full back to the control block, which derives stop_fetch from it.

Parameters:
- DEPTH, 8, number of entries; power of 2, >= 4
- XLEN, 32, instruction and PC width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all contents (taken jump)
- stall  in  1  hold read side; no pop this cycle
- wr_valid1  in  1  fetch slot 1 valid
- wr_instr1  in  XLEN  fetch slot 1 instruction
- wr_pc1  in  XLEN  fetch slot 1 PC
- wr_valid2  in  1  fetch slot 2 valid
- wr_instr2  in  XLEN  fetch slot 2 instruction
- wr_pc2  in  XLEN  fetch slot 2 PC
- rd_valid1  out  1  decode slot 1 entry valid
- rd_instr1  out  XLEN  oldest instruction
- rd_pc1  out  XLEN  oldest PC
- rd_valid2  out  1  decode slot 2 entry valid
- rd_instr2  out  XLEN  second-oldest instruction
- rd_pc2  out  XLEN  second-oldest PC
- fifo_full  out  1  fewer than 2 free entries
- fifo_empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr and count reset to 0.
  - Outputs at reset: fifo_empty=1, fifo_full=0, count=0, rd_valid1=0, rd_valid2=0.
  - rd_instr* and rd_pc* reset to 0.
  - Reset mid-operation drops all entries immediately.
- Storage is a circular buffer. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately.
- Read side is show-ahead and combinational from registered state:
  - rd_valid1 = (count >= 1); rd_valid2 = (count >= 2).
  - Slot 1 = mem[rd_ptr]; slot 2 = mem[rd_ptr+1 mod DEPTH].
  - When rd_valid is 0, the matching rd_instr and rd_pc are driven to 0.
- Pop:
  - If !stall && !flush, at the clock edge pop_n = rd_valid1 + rd_valid2.
  - rd_ptr advances by pop_n. Decode always consumes every valid slot presented.
- Write:
  - push_n = wr_valid1 + wr_valid2, taken only when fifo_full==0 and flush==0.
  - Compaction: if only wr_valid2 is set, slot 2 is written at wr_ptr.
  - If both are set, slot 1 goes to wr_ptr and slot 2 to wr_ptr+1, preserving program order.
  - Writes presented while fifo_full=1 are dropped. Fetch is required to hold them; no error flag.
- fifo_full = (count >= DEPTH-1). It is computed from registered count only, so it has no combinational path from wr_*/stall.
- Simultaneous push and pop: count_next = count + push_n - pop_n. Full is evaluated on pre-pop count (conservative).
- Flush:
  - Takes priority over stall and over same-cycle writes: pointers and count go to 0 and incoming writes are discarded.
  - Next cycle: rd_valid1=0.
- Latency: an entry written at edge N is visible on rd_* after edge N (1-cycle write-to-read). No bypass when empty.
- Invariant: 0 <= count <= DEPTH; count never exceeds DEPTH given the full rule.

Optional Feature:
- Macro: FIFO_PERF_CNT_EN
- With the macro defined, adds outputs perf_full_cycles[31:0] and perf_flush_count[31:0]:
  - perf_full_cycles counts cycles with fifo_full=1.
  - perf_flush_count counts flush pulses.
  - Both saturate at 32'hFFFF_FFFF and reset to 0 on rst only; flush does not clear them.
- Without the macro: ports and logic are absent, and functional behaviour is identical.

Decomposition:
- Shared package (core_pkg): fetch_entry_t struct {instr[XLEN-1:0], pc[XLEN-1:0]} and the default FIFO_DEPTH constant.
- One sub-module, instr_fifo_ram: DEPTH x fetch_entry_t register array.
  - Two write ports with enables, no reset on data.
  - Two asynchronous read ports.
- Pointer, count and flag logic live in the top module.

Test Plan:
- Reset then push {0x00000013@0x0, 0x00100093@0x4} -> next cycle rd_valid1=rd_valid2=1, rd_pc1=0x0, rd_pc2=0x4, count=2.
- Push pairs with stall=1 until count=7 -> fifo_full=1; a further push of PC 0x40 is dropped and count stays 7; releasing stall pops 2 -> count=5, fifo_full=0.
- Only wr_valid2 set (PC 0x8), FIFO empty -> entry lands in rd slot 1: rd_pc1=0x8, rd_valid2=0, count=1.
- count=3, assert flush together with a push and stall=1 -> next cycle count=0, fifo_empty=1, pushed data not present.
- Steady state, push 2 / pop 2 per cycle for 20 cycles, DEPTH=8 -> pointers wrap; PCs leave in strict increasing order and count stays constant.
- rst pulsed asynchronously mid-cycle with count=6 -> outputs go to reset values before the next clock edge.
